if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction-fetch front end feeding the IF/ID register. Issues sequential word fetches to a
//  latency-tolerant instruction memory port, buffers returned words in an in-order queue and presents
//  {instr, pc, pc+4} to decode with a valid/ready handshake.
//  Branch/jump redirects from execute flush the queue and discard fetches already in flight.
// PARAMETERS
//  DEPTH     4      queue entries; also the cap on (queued + outstanding) fetches; power of 2, >=2
//  RESET_PC  32'h0  fetch address after reset
// PORTS
//  clk             in   1   single clock; all state updates on posedge
//  rst             in   1   reset; synchronous, active-high
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  fetch address, word aligned
//  imem_rsp_valid  in   1   response valid; responses return in request order, latency >=1 cycle
//  imem_rsp_data   in   32  instruction word
//  redirect        in   1   PC redirect (PCSrcE)
//  redirect_pc     in   32  new fetch address (PCTargetE)
//  instr_valid     out  1   head entry valid to decode
//  instr_ready     in   1   decode consumes head (driven as !StallD)
//  instr           out  32  head instruction word
//  pc              out  32  address of head instruction
//  pcplus4         out  32  pc + 4
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, head_pc=RESET_PC, queue empty, outstanding=0, drop=0;
//    imem_req_valid=0 and instr_valid=0 in the reset cycle.
//  - Request: imem_req_valid = !rst && (count + outstanding < DEPTH); addr = fetch_pc.
//    On req handshake fetch_pc += 4 (mod 2^32) and outstanding++.
//  - Response: if drop>0, drop-- and word discarded; else word pushed at tail. outstanding-- either way.
//    A response is visible at instr no earlier than the cycle after imem_rsp_valid (no bypass).
//  - Pop: instr_valid = (count != 0); on instr_valid && instr_ready, head advances and head_pc += 4.
//    instr/pc/pcplus4 are stable while instr_valid && !instr_ready.
//  - Redirect (highest priority): next cycle queue empty, fetch_pc=head_pc=redirect_pc,
//    drop = all requests still unanswered after this cycle (incl. one accepted this cycle), pop ignored,
//    response arriving this cycle discarded. Back-to-back redirects accumulate drop correctly.
//    instr_valid=0 in the cycle after redirect.
//  - Push and pop in the same cycle: count unchanged. Full: no new request, never overflows because
//    count+outstanding <= DEPTH is invariant. Empty: instr_valid=0, decode sees bubble.
//  - imem_rsp_valid with outstanding==0 is illegal (assertion). Counters are $clog2(DEPTH+1) bits.
//  - Reset mid-operation: all state returns to reset values; in-flight responses after reset are not
//    tracked (memory port is reset together with this block).
// STRUCTURE
//  - Shared header riscv_defines.vh: RESET_PC default, NOP encoding 32'h00000013, XLEN=32.
//  - One sub-module: ifq_fifo (synchronous DEPTH x 32 FIFO, push/pop/clear, count output).
//  - Top holds fetch_pc, head_pc, outstanding and drop counters, and request/redirect control.
// TESTING
//  1 Reset, req_ready=1, 1-cycle rsp latency, instr_ready=1 -> instrs at pc 0,4,8,... one per cycle
//    after fill, pcplus4=pc+4.
//  2 instr_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, then req_valid=0;
//    head stays pc=0 until ready=1.
//  3 3-cycle latency, 3 fetches in flight, redirect to 32'h100 -> 3 stale rsps dropped,
//    first instr_valid shows pc=32'h100.
//  4 Redirect in same cycle as req handshake and rsp -> that rsp dropped, accepted request
//    counted in drop, no stale word at output.
//  5 Redirect on two consecutive cycles (0x200 then 0x300) -> output resumes at 0x300, no word from
//    0x200 or older stream.
//  6 rst asserted with 2 queued and 2 outstanding -> next cycle instr_valid=0, imem_req_addr=RESET_PC.

Source files
------------

// File: rtl/if_prefetch_queue_pkg.sv
// Shared fetch-side types and constants for the prefetch queue.
// XLEN, reset PC default, NOP bubble encoding, IF/ID head bundle.
package if_prefetch_queue_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t pcplus4;
  } if_id_t;

  function automatic word_t pcNext(word_t p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// ifq_fifo: synchronous DEPTH x XLEN in-order word queue.
// Ports: clk, clear, push/wdata, pop/rdata (head), count.
module ifq_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            push,
  input  logic [XLEN-1:0] wdata,
  input  logic            pop,
  output logic [XLEN-1:0] rdata,
  output logic [CW-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential fetch, in-order word queue, redirect flush.
// Ports: clk, rst, imem_req_*/imem_rsp_*, redirect/redirect_pc, instr_valid/ready, instr, pc, pcplus4.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4
);

  localparam int CW = $clog2(DEPTH + 1);

  word_t         fetchPc;
  word_t         headPc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW-1:0] outNext;
  logic [CW:0]   inUse;
  word_t         fifoData;
  logic          reqFire;
  logic          rspTake;
  logic          popFire;
  if_id_t        head;

  // Queued plus in-flight words never exceed DEPTH, so a push
  // always finds a free slot.
  assign inUse = {1'b0, count} + {1'b0, outstanding};

  assign imem_req_valid = !rst && (inUse < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetchPc;

  assign reqFire = imem_req_valid && imem_req_ready;
  assign rspTake = imem_rsp_valid && (drop == '0) && !redirect;

  assign instr_valid = !rst && (count != '0);
  assign popFire     = instr_valid && instr_ready && !redirect;

  assign outNext = outstanding + CW'(reqFire) - CW'(imem_rsp_valid);

  ifq_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .clear (rst || redirect),
    .push  (rspTake),
    .wdata (imem_rsp_data),
    .pop   (popFire),
    .rdata (fifoData),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc     <= RESET_PC;
      headPc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outNext;
      if (redirect) begin
        // Every word still owed by memory belongs to the old stream.
        fetchPc <= redirect_pc;
        headPc  <= redirect_pc;
        drop    <= outNext;
      end else begin
        if (reqFire)
          fetchPc <= pcNext(fetchPc);
        if (popFire)
          headPc <= pcNext(headPc);
        if (imem_rsp_valid && (drop != '0))
          drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid)
      assert (outstanding != '0);
  end

  assign head = '{
    instr:   instr_valid ? fifoData : NOP,
    pc:      headPc,
    pcplus4: pcNext(headPc)
  };

  assign instr   = head.instr;
  assign pc      = head.pc;
  assign pcplus4 = head.pcplus4;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with an in-order latency memory.
// Memory returns ~addr as the instruction word for each fetch.
module tb_if_prefetch_queue;
  import if_prefetch_queue_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic        rspValid;
  logic [31:0] rspData;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instrW;
  logic [31:0] pcW;
  logic [31:0] pcp4W;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  int reqCount = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memEnt_t;

  memEnt_t     memQ[$];
  logic        hs;
  logic        rstS;
  logic        shown;
  logic [31:0] hsAddr;

  if_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (reqValid),
    .imem_req_ready (reqReady),
    .imem_req_addr  (reqAddr),
    .imem_rsp_valid (rspValid),
    .imem_rsp_data  (rspData),
    .redirect       (redirect),
    .redirect_pc    (redirectPc),
    .instr_valid    (instrValid),
    .instr_ready    (instrReady),
    .instr          (instrW),
    .pc             (pcW),
    .pcplus4        (pcp4W)
  );

  // In-order memory: a request accepted at edge c is shown
  // during cycle c+lat-1 and retired at the following edge.
  initial begin
    rspValid = 1'b0;
    rspData  = '0;
    shown    = 1'b0;
    forever begin
      @(negedge clk);
      hs     = reqValid && reqReady;
      hsAddr = reqAddr;
      rstS   = rst;
      if (hs && !rstS)
        reqCount++;
      @(posedge clk);
      cyc++;
      if (rstS) begin
        memQ.delete();
        shown = 1'b0;
      end else begin
        if (shown)
          void'(memQ.pop_front());
        if (hs)
          memQ.push_back('{hsAddr, cyc + lat - 1});
      end
      #1;
      if (memQ.size() > 0 && memQ[0].due <= cyc) begin
        rspValid = 1'b1;
        rspData  = ~memQ[0].addr;
        shown    = 1'b1;
      end else begin
        rspValid = 1'b0;
        shown    = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instrValid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic doReset();
    tick();
    rst        = 1'b1;
    reqReady   = 1'b0;
    instrReady = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    repeat (2) tick();
    rst      = 1'b0;
    reqCount = 0;
  endtask

  task automatic test_reset();
    tick();
    rst        = 1'b1;
    reqReady   = 1'b1;
    instrReady = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (reqValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_valid got %b exp 0", reqValid);
    end
    checks++;
    if (instrValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_instr_valid got %b exp 0", instrValid);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (reqValid !== 1'b1 || reqAddr !== 32'h0) begin
      errors++;
      $display("FAIL rst_first_req got v=%b a=%h exp v=1 a=0", reqValid, reqAddr);
    end
    checks++;
    if (instrValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_bypass got %b exp 0", instrValid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    int n;
    bit seen;
    lat = 1;
    doReset();
    reqReady   = 1'b1;
    instrReady = 1'b1;
    exp  = 32'h0;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && n < 8; i++) begin
      @(negedge clk);
      if (instrValid) begin
        seen = 1'b1;
        checks++;
        if (pcW !== exp) begin
          errors++;
          $display("FAIL stream_pc got %h exp %h", pcW, exp);
        end
        checks++;
        if (instrW !== ~exp) begin
          errors++;
          $display("FAIL stream_instr got %h exp %h", instrW, ~exp);
        end
        checks++;
        if (pcp4W !== exp + 32'd4) begin
          errors++;
          $display("FAIL stream_pcplus4 got %h exp %h", pcp4W, exp + 32'd4);
        end
        exp += 32'd4;
        n++;
      end else if (seen) begin
        checks++;
        errors++;
        $display("FAIL stream_gap got valid=0 exp valid=1 at pc %h", exp);
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL stream_count got %0d exp 8", n);
    end
    tick();
  endtask

  task automatic test_stall();
    lat = 1;
    doReset();
    reqReady   = 1'b1;
    instrReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instrValid) begin
        checks++;
        if (pcW !== 32'h0 || instrW !== ~32'h0) begin
          errors++;
          $display("FAIL stall_head got pc=%h i=%h exp pc=0", pcW, instrW);
        end
      end
    end
    checks++;
    if (reqValid !== 1'b0) begin
      errors++;
      $display("FAIL stall_req_valid got %b exp 0", reqValid);
    end
    checks++;
    if (instrValid !== 1'b1) begin
      errors++;
      $display("FAIL stall_valid got %b exp 1", instrValid);
    end
    tick();
    checks++;
    if (reqCount != 4) begin
      errors++;
      $display("FAIL stall_req_count got %0d exp 4", reqCount);
    end
    instrReady = 1'b1;
    @(negedge clk);
    checks++;
    if (pcW !== 32'h0) begin
      errors++;
      $display("FAIL stall_release_pc got %h exp 0", pcW);
    end
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b1 || pcW !== 32'h4) begin
      errors++;
      $display("FAIL stall_next_pc got v=%b pc=%h exp pc=4", instrValid, pcW);
    end
    tick();
  endtask

  task automatic test_redirect_inflight();
    bit ok;
    lat = 3;
    doReset();
    reqReady   = 1'b1;
    instrReady = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b0) begin
      errors++;
      $display("FAIL rinf_pre_valid got %b exp 0", instrValid);
    end
    tick();
    checks++;
    if (reqCount != 3) begin
      errors++;
      $display("FAIL rinf_in_flight got %0d exp 3", reqCount);
    end
    reqReady   = 1'b0;
    redirect   = 1'b1;
    redirectPc = 32'h100;
    tick();
    redirect = 1'b0;
    reqReady = 1'b1;
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b0) begin
      errors++;
      $display("FAIL rinf_bubble got %b exp 0", instrValid);
    end
    waitValid(ok);
    checks++;
    if (!ok || pcW !== 32'h100 || instrW !== ~32'h100) begin
      errors++;
      $display("FAIL rinf_first got ok=%b pc=%h i=%h exp pc=100", ok, pcW, instrW);
    end
    waitValid(ok);
    checks++;
    if (!ok || pcW !== 32'h104) begin
      errors++;
      $display("FAIL rinf_second got ok=%b pc=%h exp 104", ok, pcW);
    end
    tick();
  endtask

  task automatic test_redirect_handshake();
    bit ok;
    lat = 1;
    doReset();
    reqReady   = 1'b1;
    instrReady = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b1 || pcW !== 32'h0) begin
      errors++;
      $display("FAIL rhs_pre got v=%b pc=%h exp v=1 pc=0", instrValid, pcW);
    end
    tick();
    redirect   = 1'b1;
    redirectPc = 32'h400;
    @(negedge clk);
    checks++;
    if (reqValid !== 1'b1) begin
      errors++;
      $display("FAIL rhs_req_fire got %b exp 1", reqValid);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b0) begin
      errors++;
      $display("FAIL rhs_bubble got %b exp 0", instrValid);
    end
    checks++;
    if (reqAddr !== 32'h400) begin
      errors++;
      $display("FAIL rhs_fetch_addr got %h exp 400", reqAddr);
    end
    waitValid(ok);
    checks++;
    if (!ok || pcW !== 32'h400 || instrW !== ~32'h400) begin
      errors++;
      $display("FAIL rhs_first got ok=%b pc=%h i=%h exp pc=400", ok, pcW, instrW);
    end
    waitValid(ok);
    checks++;
    if (!ok || pcW !== 32'h404 || instrW !== ~32'h404) begin
      errors++;
      $display("FAIL rhs_second got ok=%b pc=%h i=%h exp pc=404", ok, pcW, instrW);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] exp;
    lat = 2;
    doReset();
    reqReady   = 1'b1;
    instrReady = 1'b1;
    repeat (3) tick();
    redirect   = 1'b1;
    redirectPc = 32'h200;
    tick();
    redirectPc = 32'h300;
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_bubble1 got %b exp 0", instrValid);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b0 || reqAddr !== 32'h300) begin
      errors++;
      $display("FAIL b2b_bubble2 got v=%b a=%h exp v=0 a=300", instrValid, reqAddr);
    end
    exp = 32'h300;
    for (int k = 0; k < 3; k++) begin
      waitValid(ok);
      checks++;
      if (!ok || pcW !== exp || instrW !== ~exp) begin
        errors++;
        $display("FAIL b2b_word got ok=%b pc=%h i=%h exp pc=%h", ok, pcW, instrW, exp);
      end
      exp += 32'd4;
    end
    tick();
  endtask

  task automatic test_reset_midop();
    lat = 3;
    doReset();
    reqReady   = 1'b1;
    instrReady = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b1 || pcW !== 32'h0 || reqValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre got v=%b pc=%h rv=%b exp v=1 pc=0 rv=0", instrValid, pcW, reqValid);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b0 || reqValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_cycle got v=%b rv=%b exp 0 0", instrValid, reqValid);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (instrValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_valid got %b exp 0", instrValid);
    end
    checks++;
    if (reqValid !== 1'b1 || reqAddr !== 32'h0) begin
      errors++;
      $display("FAIL mid_after_req got v=%b a=%h exp v=1 a=0", reqValid, reqAddr);
    end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    reqReady   = 1'b0;
    instrReady = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_handshake();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
